// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req burst producers.
// Optional beat limit per grant: define FIFO_ARB_BURST_LIMIT_EN.
module fifo_wr_arbiter #(
  parameter int data_width  = 8,
  parameter int num_req     = 4,
  parameter int idx_width   = 2,
  parameter int max_burst   = 8,
  parameter int burst_width = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req-1:0]            req_last,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [data_width-1:0]         fifo_data_in,
  output logic [idx_width-1:0]          grant_id,
  output logic                          busy
);

  if (num_req < 2 || num_req > 16 || num_req > (1 << idx_width)) begin : g_bad_num_req
    $error("fifo_wr_arbiter: num_req out of range for idx_width");
  end
  if (max_burst < 1 || max_burst > (1 << burst_width)) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: max_burst out of range for burst_width");
  end

  // Handshake: a word moves when req_valid[i] & req_ready[i] are both high at
  // the rising edge; only the owner ever sees ready, and only while not full.
  // busy mirrors the FSM state (BURST) for external observation.
  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [idx_width-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [idx_width-1:0]   r_owner, w_owner_nxt;
  logic [idx_width-1:0]   w_pick, w_owner_inc;
  logic                   w_any;
  logic                   w_owner_valid, w_owner_last;
  logic [data_width-1:0]  w_owner_data;
  logic                   w_xfer, w_end, w_limit;

  function automatic logic [idx_width-1:0] wrap_idx(input int v);
    int r;
    r = (v >= num_req) ? v - num_req : v;
    return idx_width'(r);
  endfunction

  // Walk offsets from high to low so the closest requester above rr_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    for (int k = num_req - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_any  = 1'b1;
        w_pick = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_owner_valid = req_valid[r_owner];
  assign w_owner_last  = req_last[r_owner];
  assign w_owner_data  = req_data[r_owner*data_width +: data_width];
  assign w_owner_inc   = (r_owner == idx_width'(num_req - 1)) ? '0 : r_owner + 1'b1;

  assign busy         = (r_state == S_BURST);
  assign grant_id     = r_owner;
  assign w_xfer       = busy & w_owner_valid & ~fifo_full;
  assign fifo_wr_en   = w_xfer;
  assign fifo_data_in = w_xfer ? w_owner_data : '0;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[r_owner] = ~fifo_full;
  end

`ifdef FIFO_ARB_BURST_LIMIT_EN
  logic [burst_width-1:0] r_beat_cnt, w_beat_cnt_nxt;
  assign w_limit = (({1'b0, r_beat_cnt} + 1'b1) == (burst_width + 1)'(max_burst));
`else
  assign w_limit = 1'b0;
`endif

  assign w_end = w_xfer & (w_owner_last | w_limit);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
`ifdef FIFO_ARB_BURST_LIMIT_EN
    w_beat_cnt_nxt = r_beat_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BURST;
          w_owner_nxt = w_pick;
`ifdef FIFO_ARB_BURST_LIMIT_EN
          w_beat_cnt_nxt = '0;
`endif
        end
      end
      S_BURST: begin
`ifdef FIFO_ARB_BURST_LIMIT_EN
        if (w_xfer) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
`endif
        if (w_end) begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
`ifdef FIFO_ARB_BURST_LIMIT_EN
      r_beat_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
`ifdef FIFO_ARB_BURST_LIMIT_EN
      r_beat_cnt <= w_beat_cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares a single FIFO write port among `num_req` producers. Each producer hands over a burst of words with a valid/ready handshake; the arbiter grants one producer at a time and locks the grant until the burst ends. It forwards the granted producer's words to the FIFO's `data_in`/`wr_en`, and it stalls on the FIFO's `full` so that no word is ever dropped. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `data_width`, 8: word width; must match the FIFO `data_width`.
- `num_req`, 4: number of producers, 2..16.
- `idx_width`, 2: width of the producer index; `num_req` ≤ 2^`idx_width`.
- `max_burst`, 8: maximum beats per grant; used only when `FIFO_ARB_BURST_LIMIT_EN` is defined.
- `burst_width`, 4: beat-counter width; `max_burst` ≤ 2^`burst_width`.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `num_req`: bit i means producer i has a word.
- `req_last`  in  `num_req`: bit i marks producer i's current word as the final beat of its burst.
- `req_data`  in  `num_req*data_width`: producer i's word occupies bits `[i*data_width +: data_width]`.
- `req_ready`  out  `num_req`: bit i means producer i's word is accepted this cycle.
- `fifo_full`  in  1: FIFO `full`.
- `fifo_wr_en`  out  1: drives FIFO `wr_en`.
- `fifo_data_in`  out  `data_width`: drives FIFO `data_in`.
- `grant_id`  out  `idx_width`: current or most recent owner.
- `busy`  out  1: high while a burst is owned (state BURST).

## Operation
- FSM states:
  - IDLE:
    - If any `req_valid` is high, select the first set bit searching upward from `rr_ptr` with modulo-`num_req` wrap.
    - Register the winner into `owner`/`grant_id` and go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - `req_ready[owner]` = `~fifo_full`; every other `req_ready` bit is 0.
    - A transfer occurs when `req_valid[owner] & req_ready[owner]`.
    - On a transfer, `fifo_wr_en`=1 and `fifo_data_in` = the owner's slice; otherwise `fifo_wr_en`=0 and `fifo_data_in`=0.
    - A transfer with `req_last[owner]`=1 ends the burst: go to IDLE and set `rr_ptr` = `owner`+1, wrapping from `num_req`-1 to 0.
- Grant lock:
  - `req_valid` on other producers is ignored during BURST.
  - The owner dropping `req_valid` mid-burst keeps the grant; the FSM holds in BURST with no transfer.
- `fifo_full` mid-burst: stall with `req_ready[owner]`=0 and no write; the word is held by the producer and never dropped.
- In IDLE, all `req_ready` bits are 0 and `fifo_wr_en`=0.
- `rr_ptr` width is `idx_width`; it is never driven to a value ≥ `num_req`.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `owner`=0, `grant_id`=0, `busy`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_data_in`=0, beat counter=0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge n produces the first possible transfer in cycle n+1.
- `req_ready`, `fifo_wr_en` and `fifo_data_in` are combinational from state, `owner`, `req_valid`, `req_data` and `fifo_full`. Peak throughput is one word per cycle within a burst.
- Consecutive bursts always have exactly one IDLE cycle between them.
- A single-beat burst (`req_last`=1 on the first beat) takes 2 cycles: arbitration plus transfer.
- `RST_N` low at any time, including mid-burst, returns everything to reset values immediately. The partial burst is abandoned, and words already written stay in the FIFO.

## Configuration
- `FIFO_ARB_BURST_LIMIT_EN` defined:
  - A beat counter clears on entry to BURST and increments on each transfer.
  - The transfer that brings the count to `max_burst` ends the burst as if `req_last` were set: IDLE, `rr_ptr` = `owner`+1.
  - The producer must re-request to continue.
- Not defined: no counter; bursts end only on `req_last`, and a producer can hold the port indefinitely.

## Test plan
- Reset, then producer 0 alone sends `8'hFA` with last=1:
  - `grant_id`=0 and `busy`=1 one cycle after the request.
  - `fifo_wr_en` pulses once with `fifo_data_in`=`8'hFA`.
  - Back to IDLE with `rr_ptr`=1.
- All 4 producers hold `req_valid` with single-beat bursts:
  - Grants occur in order 0,1,2,3,0.
  - Each grant is separated by one IDLE cycle.
  - No producer is skipped.
- Producer 2 is in a 3-beat burst (`8'h11`,`8'h22`,`8'h33`) while producer 1 requests:
  - All three beats are written contiguously before producer 1 is granted.
  - `req_ready[1]`=0 throughout the burst.
- `fifo_full`=1 held for 3 cycles mid-burst:
  - `fifo_wr_en`=0 and `req_ready[owner]`=0 during the stall.
  - The same word is written on the first cycle after `full` drops; no loss or duplication.
- With `FIFO_ARB_BURST_LIMIT_EN` and `max_burst`=8, producer 3 offers 10 words with last only on word 10:
  - The grant ends after word 8.
  - Producer 3 is re-granted, after other pending requesters, for words 9–10.
- `RST_N` pulsed low mid-burst:
  - `busy`, `req_ready`, `fifo_wr_en` and `grant_id` go to 0 asynchronously.
  - Arbitration restarts from `rr_ptr`=0.
